// File: rtl/bus_cache_pkg.sv
// bus_cache_pkg: shared constants for the bus_cache block.
//   - FSM state encoding (plain localparams for legacy tool compatibility)
//   - LANE_ALL: full-word byte-enable mask
//   - UNCACHED_BASE_DEFAULT: default start of the uncached (I/O) region
//   - word_align(): clears the byte offset of an address
package bus_cache_pkg;

   localparam logic [2:0] ST_INIT   = 3'd0;
   localparam logic [2:0] ST_IDLE   = 3'd1;
   localparam logic [2:0] ST_LOOKUP = 3'd2;
   localparam logic [2:0] ST_REFILL = 3'd3;
   localparam logic [2:0] ST_WRITE  = 3'd4;
   localparam logic [2:0] ST_BYPASS = 3'd5;

   localparam logic [3:0]  LANE_ALL              = 4'b1111;
   localparam logic [31:0] UNCACHED_BASE_DEFAULT = 32'h8000_0000;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/bus_cache_if.sv
// bus_cache_if: simple valid/ready memory bus shared by the CPU side and the
// memory side of bus_cache.
//   addr, wdata, wr, lane, valid : driven by the master
//   rdata, ready                 : driven by the slave (ready is a one-cycle pulse)
interface bus_cache_if;

   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        wr;
   logic [3:0]  lane;
   logic        valid;
   logic        ready;

   modport master (
      output addr, wdata, wr, lane, valid,
      input  rdata, ready
   );

   modport slave (
      input  addr, wdata, wr, lane, valid,
      output rdata, ready
   );

endinterface

// File: rtl/bus_cache_line_ram.sv
// cache_line_ram: single-port line store for bus_cache, 2^INDEX_BITS entries of
// {valid, tag, data[31:0]}. Synchronous read, no reset (block-RAM inferable).
//   clk    : clock
//   addr   : line index (read and write share it)
//   tv_we  : write enable for the valid+tag field
//   be     : per-byte write enables for the data field
//   wvalid, wtag, wdata : write data
//   rvalid, rtag, rdata : registered read data of the line at addr
module cache_line_ram #(
   parameter int unsigned INDEX_BITS = 8,
   parameter int unsigned TAG_BITS   = 22
) (
   input  logic                  clk,
   input  logic [INDEX_BITS-1:0] addr,
   input  logic                  tv_we,
   input  logic [3:0]            be,
   input  logic                  wvalid,
   input  logic [TAG_BITS-1:0]   wtag,
   input  logic [31:0]           wdata,
   output logic                  rvalid,
   output logic [TAG_BITS-1:0]   rtag,
   output logic [31:0]           rdata
);

   localparam int unsigned DEPTH = 2 ** INDEX_BITS;
   localparam int unsigned WIDTH = 1 + TAG_BITS + 32;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_q;

   always_ff @(posedge clk) begin
      if (tv_we) begin
         mem[addr][WIDTH-1:32] <= {wvalid, wtag};
      end
      for (int b = 0; b < 4; b++) begin
         if (be[b]) begin
            mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      rd_q <= mem[addr];
   end

   assign rvalid = rd_q[WIDTH-1];
   assign rtag   = rd_q[WIDTH-2:32];
   assign rdata  = rd_q[31:0];

endmodule

// File: rtl/bus_cache.sv
// bus_cache: direct-mapped, write-through, no-write-allocate cache with one-word
// lines between the core bus and the external memory/peripheral bus.
// Addresses >= UNCACHED_BASE bypass the array unchanged.
//   clk, rst : clock, asynchronous active-high reset
//   flush    : (only with BUS_CACHE_FLUSH_EN) requests a full invalidate sweep
//   cpu      : slave side of the core bus
//   mem      : master side of the downstream bus
// Optional feature macro: BUS_CACHE_FLUSH_EN.
module bus_cache
   import bus_cache_pkg::*;
#(
   parameter int unsigned INDEX_BITS    = 8,
   parameter logic [31:0] UNCACHED_BASE = UNCACHED_BASE_DEFAULT
) (
   input logic         clk,
   input logic         rst,
`ifdef BUS_CACHE_FLUSH_EN
   input logic         flush,
`endif
   bus_cache_if.slave  cpu,
   bus_cache_if.master mem
);

   localparam int unsigned TAG_BITS = 32 - INDEX_BITS - 2;

   logic [2:0]            state_q, state_d;
   logic [INDEX_BITS-1:0] cnt_q, cnt_d;
   logic [31:0]           addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  wr_q, wr_d;
   logic [3:0]            lane_q, lane_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  ready_q, ready_d;
   logic                  mem_valid_q, mem_valid_d;
   logic                  mem_wr_q, mem_wr_d;
   logic [31:0]           mem_addr_q, mem_addr_d;
   logic [31:0]           mem_dout_q, mem_dout_d;
   logic [3:0]            mem_lane_q, mem_lane_d;
`ifdef BUS_CACHE_FLUSH_EN
   logic                  flush_q, flush_d;
`endif

   logic [INDEX_BITS-1:0] ram_addr;
   logic                  ram_tv_we;
   logic [3:0]            ram_be;
   logic                  ram_wvalid;
   logic [TAG_BITS-1:0]   ram_wtag;
   logic [31:0]           ram_wdata;
   logic                  ram_rvalid;
   logic [TAG_BITS-1:0]   ram_rtag;
   logic [31:0]           ram_rdata;

   logic [TAG_BITS-1:0]   tag_q;
   logic                  hit;

   assign tag_q = addr_q[31:INDEX_BITS+2];
   // RAM output always reflects addr_q's index once past IDLE.
   assign hit   = ram_rvalid && (ram_rtag == tag_q);

   cache_line_ram #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TAG_BITS)
   ) u_ram (
      .clk    (clk),
      .addr   (ram_addr),
      .tv_we  (ram_tv_we),
      .be     (ram_be),
      .wvalid (ram_wvalid),
      .wtag   (ram_wtag),
      .wdata  (ram_wdata),
      .rvalid (ram_rvalid),
      .rtag   (ram_rtag),
      .rdata  (ram_rdata)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wr_d        = wr_q;
      lane_d      = lane_q;
      rdata_d     = rdata_q;
      ready_d     = 1'b0;
      mem_valid_d = mem_valid_q;
      mem_wr_d    = mem_wr_q;
      mem_addr_d  = mem_addr_q;
      mem_dout_d  = mem_dout_q;
      mem_lane_d  = mem_lane_q;
      ram_addr    = addr_q[INDEX_BITS+1:2];
      ram_tv_we   = 1'b0;
      ram_be      = 4'b0000;
      ram_wvalid  = 1'b0;
      ram_wtag    = tag_q;
      ram_wdata   = wdata_q;
`ifdef BUS_CACHE_FLUSH_EN
      flush_d     = flush_q | flush;
`endif

      case (state_q)
         ST_INIT: begin
            ram_addr   = cnt_q;
            ram_tv_we  = 1'b1;
            ram_wvalid = 1'b0;
            ram_wtag   = '0;
            cnt_d      = cnt_q + 1'b1;
            if (cnt_q == '1) begin
               state_d = ST_IDLE;
            end
         end

         ST_IDLE: begin
            // Read issued with the live index so LOOKUP sees the line next cycle.
            ram_addr = cpu.addr[INDEX_BITS+1:2];
`ifdef BUS_CACHE_FLUSH_EN
            if (flush_q) begin
               flush_d = 1'b0;
               state_d = ST_INIT;
            end else
`endif
            // ready_q high means the held valid belongs to the request just served.
            if (cpu.valid && !ready_q) begin
               addr_d  = cpu.addr;
               wdata_d = cpu.wdata;
               wr_d    = cpu.wr;
               lane_d  = cpu.lane;
               if (cpu.addr >= UNCACHED_BASE || cpu.wr) begin
                  mem_valid_d = 1'b1;
                  mem_addr_d  = cpu.addr;
                  mem_dout_d  = cpu.wdata;
                  mem_wr_d    = cpu.wr;
                  mem_lane_d  = cpu.lane;
                  state_d     = (cpu.addr >= UNCACHED_BASE) ? ST_BYPASS : ST_WRITE;
               end else begin
                  state_d = ST_LOOKUP;
               end
            end
         end

         ST_LOOKUP: begin
            if (hit) begin
               rdata_d = ram_rdata;
               ready_d = 1'b1;
               state_d = ST_IDLE;
            end else begin
               mem_valid_d = 1'b1;
               mem_wr_d    = 1'b0;
               mem_lane_d  = LANE_ALL;
               mem_addr_d  = word_align(addr_q);
               state_d     = ST_REFILL;
            end
         end

         ST_REFILL: begin
            if (mem.ready) begin
               ram_tv_we   = 1'b1;
               ram_be      = LANE_ALL;
               ram_wvalid  = 1'b1;
               ram_wdata   = mem.rdata;
               rdata_d     = mem.rdata;
               ready_d     = 1'b1;
               mem_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         ST_WRITE: begin
            if (mem.ready) begin
               // No allocate on miss; on a hit only the enabled lanes are merged.
               if (hit) begin
                  ram_be = lane_q;
               end
               ready_d     = 1'b1;
               mem_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         ST_BYPASS: begin
            if (mem.ready) begin
               if (!wr_q) begin
                  rdata_d = mem.rdata;
               end
               ready_d     = 1'b1;
               mem_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_INIT;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wr_q        <= 1'b0;
         lane_q      <= 4'b0000;
         rdata_q     <= '0;
         ready_q     <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_dout_q  <= '0;
         mem_lane_q  <= 4'b0000;
`ifdef BUS_CACHE_FLUSH_EN
         flush_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wr_q        <= wr_d;
         lane_q      <= lane_d;
         rdata_q     <= rdata_d;
         ready_q     <= ready_d;
         mem_valid_q <= mem_valid_d;
         mem_wr_q    <= mem_wr_d;
         mem_addr_q  <= mem_addr_d;
         mem_dout_q  <= mem_dout_d;
         mem_lane_q  <= mem_lane_d;
`ifdef BUS_CACHE_FLUSH_EN
         flush_q     <= flush_d;
`endif
      end
   end

   assign cpu.rdata = rdata_q;
   assign cpu.ready = ready_q;
   assign mem.valid = mem_valid_q;
   assign mem.wr    = mem_wr_q;
   assign mem.addr  = mem_addr_q;
   assign mem.wdata = mem_dout_q;
   assign mem.lane  = mem_lane_q;

endmodule

// File: tb/tb_bus_cache.sv
// tb_bus_cache: self-checking bench for bus_cache. A behavioural line table
// predicts hit/miss, downstream traffic and read data; a randomly-delayed
// memory responder backs the downstream bus.
module tb_bus_cache;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] dout;
      logic        wr;
      logic [3:0]  lane;
   } txn_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
`ifdef BUS_CACHE_FLUSH_EN
   logic flush = 1'b0;
`endif

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   bus_cache_if cpu_bus ();
   bus_cache_if mem_bus ();

   bus_cache dut (
      .clk   (clk),
      .rst   (rst),
`ifdef BUS_CACHE_FLUSH_EN
      .flush (flush),
`endif
      .cpu   (cpu_bus),
      .mem   (mem_bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Backing memory, keyed by word address; unwritten words read a hash.
   logic [31:0] bmem [logic [29:0]];

   function automatic logic [31:0] bread(input logic [29:0] k);
      if (bmem.exists(k)) return bmem[k];
      return ({k, 2'b00} * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   // Reference cache contents: one {valid, tag, data} per index.
   bit          cv [256];
   logic [21:0] ct [256];
   logic [31:0] cd [256];

   task automatic model_clear();
      for (int i = 0; i < 256; i++) cv[i] = 1'b0;
   endtask

   // Downstream responder.
   bit          hold_mem = 1'b0;
   int          wait_cnt = 0;
   int unsigned ack_cyc  = 0;
   int unsigned n_acks   = 0;
   txn_t        txn_q[$];
   txn_t        rt;
   logic [31:0] rword;

   initial begin
      mem_bus.ready = 1'b0;
      mem_bus.rdata = '0;
   end

   always @(negedge clk) begin
      if (rst) begin
         mem_bus.ready = 1'b0;
         wait_cnt      = 0;
      end else if (mem_bus.ready) begin
         mem_bus.ready = 1'b0;
      end else if (mem_bus.valid && !hold_mem) begin
         if (wait_cnt == 0) begin
            rt.addr = mem_bus.addr;
            rt.dout = mem_bus.wdata;
            rt.wr   = mem_bus.wr;
            rt.lane = mem_bus.lane;
            txn_q.push_back(rt);
            rword = bread(mem_bus.addr[31:2]);
            if (mem_bus.wr) begin
               for (int b = 0; b < 4; b++)
                  if (mem_bus.lane[b]) rword[8*b +: 8] = mem_bus.wdata[8*b +: 8];
               bmem[mem_bus.addr[31:2]] = rword;
            end else begin
               mem_bus.rdata = rword;
            end
            mem_bus.ready = 1'b1;
            ack_cyc       = cyc;
            n_acks++;
            wait_cnt      = $urandom_range(0, 3);
         end else begin
            wait_cnt--;
         end
      end
   end

   bit prev_keep = 1'b0;

   // One CPU access; called at a negedge. keep=1 leaves valid high for the next call.
   task automatic do_access(input logic [31:0] a, input logic w, input logic [3:0] ln,
                            input logic [31:0] wd, input bit keep,
                            output int lat, output logic [31:0] rd, output int ntxn);
      bit          unc, hit, got;
      logic [7:0]  idx;
      logic [21:0] tg;
      logic [31:0] exp_data, exp_addr;
      logic [3:0]  exp_lane;
      int          exp_ntxn;
      unc      = (a >= 32'h8000_0000);
      idx      = a[9:2];
      tg       = a[31:10];
      hit      = !unc && cv[idx] && (ct[idx] == tg);
      exp_ntxn = 1;
      exp_addr = a;
      exp_lane = ln;
      exp_data = '0;
      if (unc) begin
         if (!w) exp_data = bread(a[31:2]);
      end else if (w) begin
         if (hit)
            for (int b = 0; b < 4; b++) if (ln[b]) cd[idx][8*b +: 8] = wd[8*b +: 8];
      end else if (hit) begin
         exp_ntxn = 0;
         exp_data = cd[idx];
      end else begin
         exp_addr = {a[31:2], 2'b00};
         exp_lane = 4'hF;
         exp_data = bread(a[31:2]);
         cv[idx]  = 1'b1;
         ct[idx]  = tg;
         cd[idx]  = exp_data;
      end

      txn_q.delete();
      cpu_bus.addr  = a;
      cpu_bus.wdata = wd;
      cpu_bus.wr    = w;
      cpu_bus.lane  = ln;
      cpu_bus.valid = 1'b1;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 1000) begin
         @(negedge clk);
         lat++;
         got = cpu_bus.ready;
      end
      rd   = cpu_bus.rdata;
      ntxn = txn_q.size();

      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL access_timeout addr=%h: no cpu_ready after %0d cycles, required a pulse",
                  a, lat);
      end else begin
         n_tests++;
         if (ntxn != exp_ntxn) begin
            n_fail++;
            $display("FAIL mem_txn_count addr=%h: got %0d, required %0d", a, ntxn, exp_ntxn);
         end else if (exp_ntxn == 1) begin
            n_tests++;
            if (txn_q[0].addr !== exp_addr || txn_q[0].wr !== w || txn_q[0].lane !== exp_lane
                || (w && txn_q[0].dout !== wd)) begin
               n_fail++;
               $display("FAIL mem_txn_fields: got addr=%h wr=%b lane=%b dout=%h, required addr=%h wr=%b lane=%b dout=%h",
                        txn_q[0].addr, txn_q[0].wr, txn_q[0].lane, txn_q[0].dout,
                        exp_addr, w, exp_lane, wd);
            end
            n_tests++;
            if (cyc != ack_cyc + 1 || mem_bus.valid !== 1'b0) begin
               n_fail++;
               $display("FAIL ready_after_mem_ready addr=%h: cpu_ready cycle %0d mem_valid=%b, required cycle %0d mem_valid=0",
                        a, cyc, mem_bus.valid, ack_cyc + 1);
            end
         end else begin
            n_tests++;
            if (lat != 2 + int'(prev_keep)) begin
               n_fail++;
               $display("FAIL hit_latency addr=%h: got %0d, required %0d", a, lat,
                        2 + int'(prev_keep));
            end
         end
         if (!w) begin
            n_tests++;
            if (rd !== exp_data) begin
               n_fail++;
               $display("FAIL read_data addr=%h: got %h, required %h", a, rd, exp_data);
            end
         end
      end

      prev_keep = keep;
      if (!keep) begin
         cpu_bus.valid = 1'b0;
         @(negedge clk);
         n_tests++;
         if (cpu_bus.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_pulse_width addr=%h: cpu_ready=%b one cycle later, required 0",
                     a, cpu_bus.ready);
         end
      end
   endtask

   task automatic rand_op(output logic [31:0] a, output logic w, output logic [3:0] ln,
                          output logic [31:0] wd);
      logic [31:0] tg, ix, off;
      tg  = $urandom_range(0, 2);
      ix  = $urandom_range(0, 3);
      off = $urandom_range(0, 3);
      if ($urandom_range(0, 4) == 0) a = 32'h8000_0000 | (ix << 2) | off;
      else                           a = (tg << 10) | (ix << 2) | off;
      w  = $urandom_range(0, 2) == 0;
      ln = 4'($urandom_range(1, 15));
      wd = $urandom;
   endtask

   int          lat, ntxn;
   logic [31:0] rd;

   task automatic test_reset();
      rst = 1'b0;
      #1 rst = 1'b1;
      #3;
      n_tests++; if (cpu_bus.ready !== 1'b0) begin n_fail++;
         $display("FAIL reset_cpu_ready: got %b, required 0", cpu_bus.ready); end
      n_tests++; if (cpu_bus.rdata !== 32'h0) begin n_fail++;
         $display("FAIL reset_cpu_rdata: got %h, required 0", cpu_bus.rdata); end
      n_tests++; if (mem_bus.valid !== 1'b0) begin n_fail++;
         $display("FAIL reset_mem_valid: got %b, required 0", mem_bus.valid); end
      n_tests++; if (mem_bus.wr !== 1'b0) begin n_fail++;
         $display("FAIL reset_mem_wr: got %b, required 0", mem_bus.wr); end
      n_tests++; if (mem_bus.addr !== 32'h0) begin n_fail++;
         $display("FAIL reset_mem_addr: got %h, required 0", mem_bus.addr); end
      n_tests++; if (mem_bus.wdata !== 32'h0) begin n_fail++;
         $display("FAIL reset_mem_dout: got %h, required 0", mem_bus.wdata); end
      n_tests++; if (mem_bus.lane !== 4'h0) begin n_fail++;
         $display("FAIL reset_mem_lane: got %b, required 0", mem_bus.lane); end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_clear();
      bmem[30'h40] = 32'hDEAD_BEEF;
      do_access(32'h0000_0100, 1'b0, 4'hF, 32'h0, 1'b0, lat, rd, ntxn);
      n_tests++; if (lat <= 257) begin n_fail++;
         $display("FAIL init_sweep_hold: cpu_ready after %0d cycles, required > 257", lat); end
      n_tests++; if (rd !== 32'hDEAD_BEEF) begin n_fail++;
         $display("FAIL first_refill_data: got %h, required deadbeef", rd); end
   endtask

   task automatic test_read_hit();
      do_access(32'h0000_0100, 1'b0, 4'hF, 32'h0, 1'b0, lat, rd, ntxn);
      n_tests++; if (ntxn != 0 || lat != 2 || rd !== 32'hDEAD_BEEF) begin n_fail++;
         $display("FAIL read_hit: got txns=%0d lat=%0d data=%h, required 0/2/deadbeef",
                  ntxn, lat, rd); end
   endtask

   task automatic test_store_merge();
      do_access(32'h0000_0100, 1'b1, 4'b0010, 32'hAAAA_AAAA, 1'b0, lat, rd, ntxn);
      n_tests++; if (bmem[30'h40] !== 32'hDEAD_AAEF) begin n_fail++;
         $display("FAIL store_to_memory: got %h, required deadaaef", bmem[30'h40]); end
      do_access(32'h0000_0100, 1'b0, 4'hF, 32'h0, 1'b0, lat, rd, ntxn);
      n_tests++; if (ntxn != 0 || rd !== 32'hDEAD_AAEF) begin n_fail++;
         $display("FAIL store_merge_read: got txns=%0d data=%h, required 0/deadaaef", ntxn, rd); end
   endtask

   task automatic test_bypass();
      int unsigned a0;
      bmem[30'h2000_0004] = 32'h1234_5678;
      a0 = n_acks;
      do_access(32'h8000_0010, 1'b0, 4'hF, 32'h0, 1'b0, lat, rd, ntxn);
      do_access(32'h8000_0010, 1'b0, 4'hF, 32'h0, 1'b0, lat, rd, ntxn);
      n_tests++; if (n_acks - a0 != 2 || rd !== 32'h1234_5678) begin n_fail++;
         $display("FAIL bypass_reads: got %0d mem reads data=%h, required 2/12345678",
                  n_acks - a0, rd); end
      do_access(32'h0000_0100, 1'b0, 4'hF, 32'h0, 1'b0, lat, rd, ntxn);
      n_tests++; if (ntxn != 0) begin n_fail++;
         $display("FAIL hit_after_bypass: got %0d mem txns, required 0", ntxn); end
   endtask

   task automatic test_alias();
      do_access(32'h0000_0500, 1'b0, 4'hF, 32'h0, 1'b0, lat, rd, ntxn);
      do_access(32'h0000_0100, 1'b0, 4'hF, 32'h0, 1'b0, lat, rd, ntxn);
      n_tests++; if (ntxn != 1 || rd !== 32'hDEAD_AAEF) begin n_fail++;
         $display("FAIL alias_evict: got txns=%0d data=%h, required 1/deadaaef", ntxn, rd); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, wd;
      logic        w;
      logic [3:0]  ln;
      for (int i = 0; i < 12; i++) begin
         rand_op(a, w, ln, wd);
         do_access(a, w, ln, wd, i != 11, lat, rd, ntxn);
      end
   endtask

   task automatic test_random();
      logic [31:0] a, wd;
      logic        w;
      logic [3:0]  ln;
      for (int i = 0; i < 300; i++) begin
         rand_op(a, w, ln, wd);
         do_access(a, w, ln, wd, (i != 299) && ($urandom_range(0, 3) == 0), lat, rd, ntxn);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      hold_mem      = 1'b1;
      cpu_bus.addr  = 32'h8000_0020;
      cpu_bus.wr    = 1'b0;
      cpu_bus.lane  = 4'hF;
      cpu_bus.valid = 1'b1;
      n = 0;
      while (!mem_bus.valid && n < 10) begin @(negedge clk); n++; end
      n_tests++; if (mem_bus.valid !== 1'b1) begin n_fail++;
         $display("FAIL reset_mid_start: mem_valid=%b, required 1", mem_bus.valid); end
      rst = 1'b1;
      #1;
      n_tests++; if (mem_bus.valid !== 1'b0 || cpu_bus.ready !== 1'b0) begin n_fail++;
         $display("FAIL reset_mid_abort: mem_valid=%b cpu_ready=%b, required 0/0",
                  mem_bus.valid, cpu_bus.ready); end
      cpu_bus.valid = 1'b0;
      repeat (2) @(negedge clk);
      rst       = 1'b0;
      hold_mem  = 1'b0;
      prev_keep = 1'b0;
      model_clear();
      do_access(32'h0000_0100, 1'b0, 4'hF, 32'h0, 1'b0, lat, rd, ntxn);
      n_tests++; if (lat <= 257 || ntxn != 1) begin n_fail++;
         $display("FAIL reset_mid_resweep: got lat=%0d txns=%0d, required >257/1", lat, ntxn); end
   endtask

`ifdef BUS_CACHE_FLUSH_EN
   task automatic test_flush();
      int  n;
      bit  got;
      do_access(32'h0000_0100, 1'b0, 4'hF, 32'h0, 1'b0, lat, rd, ntxn);
      hold_mem      = 1'b1;
      cpu_bus.addr  = 32'h0000_0200;
      cpu_bus.wr    = 1'b0;
      cpu_bus.lane  = 4'hF;
      cpu_bus.valid = 1'b1;
      n = 0;
      while (!mem_bus.valid && n < 10) begin @(negedge clk); n++; end
      flush = 1'b1;
      @(negedge clk);
      flush    = 1'b0;
      hold_mem = 1'b0;
      n   = 0;
      got = 1'b0;
      while (!got && n < 20) begin @(negedge clk); n++; got = cpu_bus.ready; end
      n_tests++; if (!got || cpu_bus.rdata !== bread(30'h80)) begin n_fail++;
         $display("FAIL flush_refill_completes: ready=%b data=%h, required 1/%h",
                  got, cpu_bus.rdata, bread(30'h80)); end
      cpu_bus.valid = 1'b0;
      @(negedge clk);
      model_clear();
      do_access(32'h0000_0100, 1'b0, 4'hF, 32'h0, 1'b0, lat, rd, ntxn);
      n_tests++; if (ntxn != 1 || lat <= 256) begin n_fail++;
         $display("FAIL flush_invalidates: got txns=%0d lat=%0d, required 1/>256", ntxn, lat); end
   endtask
`endif

   initial begin
      cpu_bus.addr  = '0;
      cpu_bus.wdata = '0;
      cpu_bus.wr    = 1'b0;
      cpu_bus.lane  = 4'h0;
      cpu_bus.valid = 1'b0;
      test_reset();
      test_read_hit();
      test_store_merge();
      test_bypass();
      test_alias();
      test_back_to_back();
      test_random();
      test_reset_mid();
`ifdef BUS_CACHE_FLUSH_EN
      test_flush();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
